// File: rtl/puf_eval_ctrl_if.sv
// Challenge request, voted result and PUF-array connections bundled for the evaluation controller.
// slave = controller view, master = host/array view.
interface puf_eval_ctrl_if #(
    parameter int CW = 16,
    parameter int RW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_challenge;
    logic [CW-1:0] puf_challenge;
    logic          puf_pulse;
    logic [RW-1:0] puf_response;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_response;
    logic [RW-1:0] out_unstable;

    modport slave (
        input  in_valid, in_challenge, puf_response, out_ready,
        output in_ready, puf_challenge, puf_pulse, out_valid, out_response, out_unstable
    );

    modport master (
        output in_valid, in_challenge, puf_response, out_ready,
        input  in_ready, puf_challenge, puf_pulse, out_valid, out_response, out_unstable
    );
endinterface

// File: rtl/puf_eval_ctrl.sv
// Sequences NUM_EVAL pulse/settle/sample evaluations of the PUF array and majority-votes each response bit.
// Latency 1+NUM_EVAL*(SETUP+PULSE+SETTLE+1) cycles; one request in flight, result held until out_ready.
module puf_eval_ctrl #(
    parameter int CW         = 16,
    parameter int RW         = 16,
    parameter int NUM_EVAL   = 5,
    parameter int SETUP_CYC  = 1,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    puf_eval_ctrl_if.slave    bus
);
    localparam int VW   = $clog2(NUM_EVAL + 1);
    localparam int MAXC = (SETUP_CYC > PULSE_CYC)
                        ? ((SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC)
                        : ((PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC);
    localparam int CYW  = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_SETTLE, S_SAMPLE, S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CYW-1:0]  r_cyc;
    logic [VW-1:0]   r_eval;
    logic [VW-1:0]   r_vote [RW];
    logic [VW-1:0]   w_vote_nxt [RW];
    logic [RW-1:0]   w_maj;
    logic [RW-1:0]   w_unst;
    logic [RW-1:0]   r_sync1;
    logic [RW-1:0]   r_sync2;
    logic [CW-1:0]   r_chal;
    logic            r_pulse;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [RW-1:0]   r_out_resp;
    logic [RW-1:0]   r_out_unst;
    logic            w_timed;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.in_valid && r_in_ready)      w_next = S_SETUP;
            S_SETUP:  if (r_cyc == CYW'(SETUP_CYC - 1))    w_next = S_PULSE;
            S_PULSE:  if (r_cyc == CYW'(PULSE_CYC - 1))    w_next = S_SETTLE;
            S_SETTLE: if (r_cyc == CYW'(SETTLE_CYC - 1))   w_next = S_SAMPLE;
            S_SAMPLE: w_next = (r_eval == VW'(NUM_EVAL - 1)) ? S_DONE : S_SETUP;
            S_DONE:   if (bus.out_ready)                   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_timed = (r_state == S_SETUP) || (r_state == S_PULSE) || (r_state == S_SETTLE);

    // Vote for the current sample folded in, so DONE outputs can be registered on the SAMPLE edge.
    always_comb begin
        w_maj  = '0;
        w_unst = '0;
        for (int i = 0; i < RW; i++) begin
            w_vote_nxt[i] = r_vote[i];
            if (r_sync2[i] && (r_vote[i] != VW'(NUM_EVAL)))
                w_vote_nxt[i] = r_vote[i] + VW'(1);
            w_maj[i]  = (w_vote_nxt[i] > VW'(NUM_EVAL / 2));
            w_unst[i] = (w_vote_nxt[i] != '0) && (w_vote_nxt[i] != VW'(NUM_EVAL));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_eval      <= '0;
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_chal      <= '0;
            r_pulse     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_resp  <= '0;
            r_out_unst  <= '0;
            for (int i = 0; i < RW; i++) r_vote[i] <= '0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == S_IDLE);
            r_pulse     <= (w_next == S_PULSE);
            r_out_valid <= (w_next == S_DONE);
            r_sync1     <= bus.puf_response;
            r_sync2     <= r_sync1;

            if (w_next != r_state)
                r_cyc <= '0;
            else if (w_timed)
                r_cyc <= r_cyc + CYW'(1);

            if ((r_state == S_IDLE) && (w_next == S_SETUP)) begin
                r_chal <= bus.in_challenge;
                r_eval <= '0;
                for (int i = 0; i < RW; i++) r_vote[i] <= '0;
            end

            if (r_state == S_SAMPLE) begin
                r_eval <= r_eval + VW'(1);
                for (int i = 0; i < RW; i++) r_vote[i] <= w_vote_nxt[i];
                if (w_next == S_DONE) begin
                    r_out_resp <= w_maj;
                    r_out_unst <= w_unst;
                end
            end
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.puf_challenge = r_chal;
    assign bus.puf_pulse     = r_pulse;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_response  = r_out_resp;
    assign bus.out_unstable  = r_out_unst;
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Bench for puf_eval_ctrl: vector table, hand-written corner sequences and randomized requests
// checked against a per-bit vote-count model; the PUF array is modelled as pulse-indexed responses.
module tb_puf_eval_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    puf_eval_ctrl_if #(.CW(16), .RW(16)) bus ();

    puf_eval_ctrl #(
        .CW(16), .RW(16), .NUM_EVAL(5), .SETUP_CYC(1), .PULSE_CYC(2), .SETTLE_CYC(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] ch;
        logic [79:0] rv;    // eval k response at [k*16 +: 16]
        logic [15:0] er;
        logic [15:0] eu;
        int          dly;
        bit          pre;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          edge_cnt = 0;
    int          acc_edge = -1000;
    logic [79:0] cur_resp = '0;
    logic [15:0] exp_chal = '0;
    int          pulse_bad, chal_bad, pulse_hi;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Array model: each new pulse presents the next evaluation's response.
    initial begin
        int   pidx;
        int   last_acc;
        logic prev_p;
        pidx = -1; last_acc = -1000; prev_p = 1'b0;
        bus.puf_response = '0;
        forever begin
            @(negedge clk);
            if (acc_edge != last_acc) begin
                last_acc = acc_edge;
                pidx     = -1;
            end
            if (bus.puf_pulse && !prev_p) begin
                pidx = pidx + 1;
                if (pidx < 5) bus.puf_response = cur_resp[pidx*16 +: 16];
            end
            prev_p = bus.puf_pulse;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_vote(input logic [79:0] rv);
        logic [15:0] r;
        logic [15:0] u;
        int          c;
        r = '0; u = '0;
        for (int b = 0; b < 16; b++) begin
            c = 0;
            for (int k = 0; k < 5; k++) c += int'(rv[k*16 + b]);
            r[b] = (2 * c > 5);
            u[b] = (c != 0) && (c != 5);
        end
        return {r, u};
    endfunction

    // Leaves in_valid high; the caller decides when to drop it.
    task automatic accept(input logic [15:0] ch, input logic [79:0] rv);
        int n;
        n = 0;
        bus.in_valid     = 1'b1;
        bus.in_challenge = ch;
        while (!bus.in_ready && n < 200) begin
            step();
            n++;
        end
        chk("accept_ready_seen", {31'd0, bus.in_ready}, 32'd1);
        step();
        acc_edge  = edge_cnt;
        cur_resp  = rv;
        exp_chal  = ch;
        pulse_bad = 0;
        chal_bad  = 0;
        pulse_hi  = 0;
    endtask

    // vedge = index of the first clock edge at which out_valid is sampled high.
    task automatic wait_result(input bit pre_rdy, output int vedge);
        int  n;
        int  c;
        bit  exp_p;
        n = 0;
        bus.out_ready = pre_rdy;
        while (n < 200) begin
            c = edge_cnt - acc_edge;
            if (bus.puf_challenge !== exp_chal) chal_bad++;
            if (bus.out_valid) break;
            exp_p = ((c % 8) == 1) || ((c % 8) == 2);
            if (bus.puf_pulse !== exp_p) pulse_bad++;
            if (bus.puf_pulse) pulse_hi++;
            step();
            n++;
        end
        chk("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
        vedge = bus.out_valid ? edge_cnt + 1 : -1;
    endtask

    task automatic finish_result(input int dly, output logic [15:0] r, output logic [15:0] u);
        int bad;
        bad = 0;
        r = bus.out_response;
        u = bus.out_unstable;
        if (dly > 0) begin
            bus.out_ready = 1'b0;
            for (int i = 0; i < dly; i++) begin
                step();
                if (!bus.out_valid || bus.out_response !== r || bus.out_unstable !== u) bad++;
            end
            chk("bp_hold", bad, 0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("valid_one_shot", {31'd0, bus.out_valid}, 32'd0);
        chk("ready_after_done", {31'd0, bus.in_ready}, 32'd1);
    endtask

    task automatic run_one(input logic [15:0] ch, input logic [79:0] rv,
                           input logic [15:0] er, input logic [15:0] eu,
                           input int dly, input bit pre);
        int          ve;
        logic [15:0] r, u;
        accept(ch, rv);
        bus.in_valid = 1'b0;
        wait_result(pre, ve);
        chk("latency", ve - acc_edge, 41);
        chk("pulse_shape", pulse_bad, 0);
        chk("pulse_cycles", pulse_hi, 10);
        chk("chal_hold", chal_bad, 0);
        finish_result(dly, r, u);
        chk("out_response", {16'd0, r}, {16'd0, er});
        chk("out_unstable", {16'd0, u}, {16'd0, eu});
    endtask

    initial begin
        vec_t        vt [6];
        int          ve, a1, he, bad, rises, vcnt, n;
        logic        prev;
        logic [15:0] r, base, ch;
        logic [79:0] rv;
        logic [31:0] m;

        vt[0] = '{16'h1234, {5{16'hA5C3}}, 16'hA5C3, 16'h0000, 0, 1'b1};
        vt[1] = '{16'h4321, {16'h01FF, 16'h01FF, 16'h00FE, 16'h00FE, 16'h01FF}, 16'h01FF, 16'h0101, 2, 1'b0};
        vt[2] = '{16'hBEEF, {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000}, 16'h0000, 16'hFFFF, 0, 1'b0};
        vt[3] = '{16'h0F0F, {16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF}, 16'hFFFF, 16'hFFFF, 1, 1'b1};
        vt[4] = '{16'h5555, {5{16'h0000}}, 16'h0000, 16'h0000, 0, 1'b0};
        vt[5] = '{16'hAAAA, {16'h0F00, 16'hF000, 16'h0F00, 16'hF000, 16'hF000}, 16'hF000, 16'hFF00, 3, 1'b0};

        bus.in_valid = 1'b0; bus.in_challenge = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_pulse", {31'd0, bus.puf_pulse}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_challenge", {16'd0, bus.puf_challenge}, 32'd0);
        chk("rst_resp_unst", {bus.out_response, bus.out_unstable}, 32'd0);
        rst = 1'b0;
        step();
        chk("in_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 6; i++)
            run_one(vt[i].ch, vt[i].rv, vt[i].er, vt[i].eu, vt[i].dly, vt[i].pre);

        // Backpressure with a competing request waiting.
        accept(16'hC0C0, {5{16'h1357}});
        bus.in_valid = 1'b0;
        wait_result(1'b0, ve);
        r = bus.out_response;
        bus.in_valid = 1'b1; bus.in_challenge = 16'h0F0F; bus.out_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!bus.out_valid || bus.out_response !== r || bus.in_ready) bad++;
        end
        chk("bp10_hold", bad, 0);
        chk("bp10_resp", {16'd0, r}, 32'h1357);
        bus.out_ready = 1'b1;
        step();
        he = edge_cnt;
        bus.out_ready = 1'b0;
        chk("bp10_valid_drop", {31'd0, bus.out_valid}, 32'd0);
        accept(16'h0F0F, {5{16'h2468}});
        bus.in_valid = 1'b0;
        chk("bp10_accept_edge", acc_edge - he, 1);
        wait_result(1'b0, ve);
        chk("bp10_second_chal", chal_bad, 0);
        finish_result(0, r, base);
        chk("bp10_second_resp", {16'd0, r}, 32'h2468);

        // Reset during the third evaluation's pulse.
        accept(16'h1111, {5{16'hFFFF}});
        bus.in_valid = 1'b0;
        prev = 1'b0; rises = 0; n = 0;
        while (!(rises == 3 && bus.puf_pulse) && n < 100) begin
            step();
            if (bus.puf_pulse && !prev) rises++;
            prev = bus.puf_pulse;
            n++;
        end
        chk("rst_mid_reached", rises, 3);
        rst = 1'b1;
        step();
        chk("rst_mid_pulse_off", {31'd0, bus.puf_pulse}, 32'd0);
        rst = 1'b0;
        step();
        chk("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_mid_pulse_low", {31'd0, bus.puf_pulse}, 32'd0);
        vcnt = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.out_valid || bus.puf_pulse) vcnt++;
            step();
        end
        chk("rst_mid_no_result", vcnt, 0);
        run_one(16'h7777, {5{16'h5A5A}}, 16'h5A5A, 16'h0000, 0, 1'b0);

        // Back-to-back requests with in_valid held high.
        accept(16'h0001, {5{16'h1111}});
        bus.in_challenge = 16'hFFFF;
        a1 = acc_edge;
        wait_result(1'b1, ve);
        chk("b2b_first_edge", ve - a1, 41);
        chk("b2b_first_resp", {16'd0, bus.out_response}, 32'h1111);
        step();
        chk("b2b_ready", {31'd0, bus.in_ready}, 32'd1);
        accept(16'hFFFF, {5{16'hEEEE}});
        bus.in_valid = 1'b0;
        wait_result(1'b1, ve);
        chk("b2b_second_edge", ve - a1, 83);
        chk("b2b_second_chal", chal_bad, 0);
        chk("b2b_second_resp", {16'd0, bus.out_response}, 32'hEEEE);
        step();
        bus.out_ready = 1'b0;

        // Randomized noisy responses against the vote-count model.
        for (int t = 0; t < 12; t++) begin
            base = 16'($urandom);
            ch   = 16'($urandom);
            for (int k = 0; k < 5; k++)
                rv[k*16 +: 16] = base ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            m = ref_vote(rv);
            run_one(ch, rv, m[31:16], m[15:0], int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
